// File: rtl/eth_mac_tx_frame_arb.sv
// eth_mac_tx_frame_arb
// Frame-level round-robin arbiter that shares the single 8-bit MAC tx_axis
// input among PORTS AXI-stream frame sources, in the MAC tx_clk domain.
// A grant is held from the first beat of a frame through its tlast handshake.
// Optional feature macro: ETH_TX_ARB_STALL_ABORT_EN. When it is defined, a
// frame whose source starves for STALL_TIMEOUT cycles mid-frame is closed with
// an errored beat (0x00, tlast=1, tuser=1). The rest of that source's frame is
// then dropped.
//
// Handshake rule (all streams): a beat transfers on a rising clk edge where
// tvalid and tready are both high. A source holds tdata/tlast/tuser stable
// while tvalid is high and tready is low. The arbiter's own abort beat
// follows the same rule.
module eth_mac_tx_frame_arb #(
   parameter int PORTS         = 2,
   parameter int STALL_TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [PORTS*8-1:0] s_axis_tdata,
   input  logic [PORTS-1:0]   s_axis_tvalid,
   output logic [PORTS-1:0]   s_axis_tready,
   input  logic [PORTS-1:0]   s_axis_tlast,
   input  logic [PORTS-1:0]   s_axis_tuser,
   output logic [7:0]         m_axis_tdata,
   output logic               m_axis_tvalid,
   input  logic               m_axis_tready,
   output logic               m_axis_tlast,
   output logic               m_axis_tuser,
   output logic [PORTS-1:0]   grant,
   output logic               busy,
   output logic               stall_abort,
   output logic [1:0]         state_dbg
);

   localparam int PW = $clog2(PORTS);
   localparam logic [PW-1:0] LAST_RST = PW'(PORTS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1
`ifdef ETH_TX_ARB_STALL_ABORT_EN
      ,
      ST_ABORT = 2'd2,
      ST_DROP  = 2'd3
`endif
   } state_t;

   state_t          state_q;
   state_t          state_d;
   logic [PW-1:0]   last_q;     // round-robin pointer, also the granted port index
   logic [PORTS-1:0] grant_q;
   logic [7:0]      s_byte [PORTS];
   logic [PW-1:0]   sel_idx;
   logic            sel_found;
   logic            g_valid;
   logic            g_last;
   logic            g_hs;

   // Split the flat data bus into one byte per port.
   always_comb begin
      for (int i = 0; i < PORTS; i++) begin
         s_byte[i] = s_axis_tdata[8*i +: 8];
      end
   end

   // Round-robin search: first requester upward from last+1, with wrap.
   always_comb begin
      sel_idx   = last_q;
      sel_found = 1'b0;
      for (int k = 1; k <= PORTS; k++) begin
         int idx;
         idx = int'(last_q) + k;
         if (idx >= PORTS) idx = idx - PORTS;
         if (!sel_found && s_axis_tvalid[idx[PW-1:0]]) begin
            sel_found = 1'b1;
            sel_idx   = idx[PW-1:0];
         end
      end
   end

   assign g_valid = s_axis_tvalid[last_q];
   assign g_last  = s_axis_tlast[last_q];
   assign g_hs    = g_valid && m_axis_tready;

`ifdef ETH_TX_ARB_STALL_ABORT_EN
   logic [7:0] stall_cnt_q;
   logic       beat_seen_q;
   logic       stall_trip;

   // A valid beat this cycle always wins over the trip, so a closing tlast ends normally.
   assign stall_trip = (stall_cnt_q == 8'(STALL_TIMEOUT)) && !g_valid;

   // Starvation counter: counts only after the first beat, so an idle source is never aborted.
   always_ff @(posedge clk) begin
      if (rst || state_q == ST_IDLE) begin
         stall_cnt_q <= 8'd0;
         beat_seen_q <= 1'b0;
      end else if (state_q == ST_GRANT) begin
         if (g_valid) stall_cnt_q <= 8'd0;
         else if (beat_seen_q) stall_cnt_q <= stall_cnt_q + 8'd1;
         if (g_hs) beat_seen_q <= 1'b1;
      end
   end
`else
   logic unused_cfg;
   assign unused_cfg = (STALL_TIMEOUT > 0);
`endif

   // Next-state logic and the combinational mux between the granted port and the MAC.
   always_comb begin
      state_d       = state_q;
      s_axis_tready = '0;
      m_axis_tdata  = 8'h00;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      m_axis_tuser  = 1'b0;
      stall_abort   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (sel_found) state_d = ST_GRANT;
         end
         ST_GRANT: begin
            m_axis_tdata           = s_byte[last_q];
            m_axis_tvalid          = g_valid;
            m_axis_tlast           = g_last;
            m_axis_tuser           = s_axis_tuser[last_q];
            s_axis_tready[last_q]  = m_axis_tready;
            if (g_hs && g_last) state_d = ST_IDLE;
`ifdef ETH_TX_ARB_STALL_ABORT_EN
            else if (stall_trip) state_d = ST_ABORT;
`endif
         end
`ifdef ETH_TX_ARB_STALL_ABORT_EN
         ST_ABORT: begin
            m_axis_tvalid = 1'b1;
            m_axis_tlast  = 1'b1;
            m_axis_tuser  = 1'b1;
            if (m_axis_tready) begin
               stall_abort = 1'b1;
               state_d     = ST_DROP;
            end
         end
         ST_DROP: begin
            s_axis_tready[last_q] = 1'b1;
            if (g_valid && g_last) state_d = ST_IDLE;
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   // State, pointer and grant registers; the grant is latched only when leaving IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         last_q  <= LAST_RST;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_IDLE && sel_found) begin
            last_q           <= sel_idx;
            grant_q          <= '0;
            grant_q[sel_idx] <= 1'b1;
         end else if (state_d == ST_IDLE) begin
            grant_q <= '0;
         end
      end
   end

   assign grant     = grant_q;
   assign busy      = (state_q != ST_IDLE);
   assign state_dbg = state_q;

endmodule
